// File: rtl/axi_pkg.sv
// Shared AXI constants for the instruction-fetch master and its line buffer.
package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 4;
  localparam int TAG_W      = AXI_ADDR_W - 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;
  localparam logic [AXI_LEN_W-1:0] LINE_LEN = 4'd3;

  // Tag of the 16-byte line containing a byte address.
  function automatic logic [TAG_W-1:0] line_tag(input logic [AXI_ADDR_W-1:0] addr);
    return addr[AXI_ADDR_W-1:4];
  endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// One-line instruction buffer: four words, a line tag and a valid bit.
module fetch_line_buf
  import axi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [1:0]            wr_idx_i,
  input  logic [AXI_DATA_W-1:0] wr_data_i,
  input  logic                  install_i,
  input  logic [TAG_W-1:0]      install_tag_i,
  input  logic                  install_valid_i,
  input  logic                  inval_i,
  input  logic [1:0]            rd_idx_i,
  output logic [AXI_DATA_W-1:0] rd_data_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  valid_o
);

  logic [AXI_DATA_W-1:0] words_q [4];
  logic [TAG_W-1:0]      tag_q;
  logic                  valid_q;

  // Word storage, written one beat at a time during a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) words_q[i] <= '0;
    end else if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Tag/valid: install at the end of a fill wins over invalidation.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (install_i) begin
      tag_q   <= install_tag_i;
      valid_q <= install_valid_i;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end
  end

  assign rd_data_o = words_q[rd_idx_i];
  assign tag_o     = tag_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_axi_master.sv
// Instruction-fetch front end: serves hits from a one-line buffer and fills
// misses with a 4-beat INCR read burst on AXI.
module fetch_axi_master
  import axi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [AXI_ADDR_W-1:0] fetch_addr,
  input  logic                  flush,
  output logic                  fetch_ack,
  output logic [AXI_DATA_W-1:0] fetch_data,
  output logic                  fetch_err,
  output logic [AXI_ID_W-1:0]   ARID,
  output logic [AXI_ADDR_W-1:0] ARADDR,
  output logic [AXI_LEN_W-1:0]  ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [AXI_ID_W-1:0]   RID,
  input  logic [AXI_DATA_W-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [AXI_ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  full_q, full_d;      // fourth beat already taken
  logic                  err_q, err_d;
  logic                  flush_seen_q, flush_seen_d;

  logic                  lb_valid;
  logic [TAG_W-1:0]      lb_tag;
  logic [AXI_DATA_W-1:0] lb_rd_data;
  logic                  hit, beat, last_slot, beat_bad;
  logic                  unused_bits;

  assign hit       = lb_valid && (lb_tag == line_tag(fetch_addr)) && !flush;
  assign beat      = (state_q == S_DATA) && RVALID;
  // The beat now on the bus is the fourth one of the burst.
  assign last_slot = (cnt_q == 2'd3) && !full_q;
  assign beat_bad  = (RRESP != RESP_OKAY) || (RID != '0) ||
                     (RLAST && !last_slot && !full_q) || (last_slot && !RLAST);

  // Next-state and fill bookkeeping.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    cnt_d        = cnt_q;
    full_d       = full_q;
    err_d        = err_q;
    flush_seen_d = flush_seen_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_req && !hit) begin
          req_addr_d = fetch_addr;
          cnt_d      = 2'd0;
          full_d     = 1'b0;
          err_d      = 1'b0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (flush) flush_seen_d = 1'b1;
        if (ARREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (flush) flush_seen_d = 1'b1;
        if (beat) begin
          if (!full_q) begin
            if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
            else               full_d = 1'b1;
          end
          if (beat_bad) err_d = 1'b1;
          if (RLAST) state_d = S_RESP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        flush_seen_d = 1'b0;
      end
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      cnt_q        <= 2'd0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      err_q        <= err_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  // The line is dropped when a fill starts so a partial overwrite is never hit.
  fetch_line_buf u_line_buf (
    .clk             (clk),
    .rst             (rst),
    .wr_en_i         (beat && !full_q),
    .wr_idx_i        (cnt_q),
    .wr_data_i       (RDATA),
    .install_i       (state_q == S_RESP),
    .install_tag_i   (line_tag(req_addr_q)),
    .install_valid_i (!err_q && !flush_seen_q && !flush),
    .inval_i         ((state_q == S_IDLE) && (flush || (fetch_req && !hit))),
    .rd_idx_i        ((state_q == S_RESP) ? req_addr_q[3:2] : fetch_addr[3:2]),
    .rd_data_o       (lb_rd_data),
    .tag_o           (lb_tag),
    .valid_o         (lb_valid)
  );

  assign fetch_ack  = ((state_q == S_IDLE) && fetch_req && hit) || (state_q == S_RESP);
  assign fetch_data = fetch_ack ? lb_rd_data : '0;
  assign fetch_err  = (state_q == S_RESP) && err_q;

  assign ARID    = '0;
  assign ARADDR  = {req_addr_q[AXI_ADDR_W-1:4], 4'b0000};
  assign ARLEN   = LINE_LEN;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign ARVALID = (state_q == S_ADDR);
  assign RREADY  = (state_q == S_DATA);

  assign unused_bits = ^{fetch_addr[1:0], req_addr_q[1:0]};

endmodule

// File: doc/fetch_axi_master.md
FETCH_AXI_MASTER -- requirements
Module: fetch_axi_master

Interface
REQ-001 Reset rst is synchronous and active-high; clock clk; all state updates on posedge clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 fetch_req  input  1  CPU instruction-fetch request, level; held with fetch_addr until fetch_ack.
REQ-005 fetch_addr  input  32  byte address; bits [1:0] ignored.
REQ-006 flush  input  1  one-cycle pulse; invalidates line buffer.
REQ-007 fetch_ack  output  1  one-cycle pulse; fetch_data/fetch_err valid.
REQ-008 fetch_data  output  32  requested instruction word.
REQ-009 fetch_err  output  1  fill failed (bad RRESP, RID, or burst length).
REQ-010 ARID out 4 (const 0); ARADDR out 32; ARLEN out 4; ARSIZE out 3; ARBURST out 2; ARVALID out 1; ARREADY in 1.
REQ-011 RID in 4; RDATA in 32; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1.

Function
REQ-012 States: IDLE, ADDR, DATA, RESP; one-line buffer: 4x32 words, 28-bit tag, valid bit.
REQ-013 Hit = valid & tag==fetch_addr[31:4] & !flush; IDLE with fetch_req & hit: fetch_ack=1 same cycle, fetch_data=word[fetch_addr[3:2]], fetch_err=0; stay IDLE.
REQ-014 IDLE with fetch_req & miss: latch fetch_addr into req_addr, clear beat counter and err flag, go ADDR; no ack.
REQ-015 ADDR: ARVALID=1, ARADDR={req_addr[31:4],4'b0}, ARLEN=4'd3, ARSIZE=3'b010, ARBURST=2'b01 (INCR); all stable while ARVALID; go DATA on ARVALID&ARREADY.
REQ-016 ARVALID SHALL be 0 in every state except ADDR; it SHALL NOT drop before ARREADY.
REQ-017 DATA: RREADY=1; each RVALID&RREADY beat writes RDATA into word[cnt]; cnt 2-bit, increments per beat, saturates at 3 (later beats not written).
REQ-018 err flag set on any beat with RRESP!=2'b00, RID!=4'd0, RLAST on beat<4, or beat 4 without RLAST.
REQ-019 DATA -> RESP on beat with RLAST; beats after 4th without RLAST keep DATA until RLAST.
REQ-020 RESP: fetch_ack=1 for one cycle, fetch_data=word[req_addr[3:2]], fetch_err=err; tag<=req_addr[31:4]; valid<=!err & !flush_seen; go IDLE.
REQ-021 flush in IDLE clears valid next cycle; flush during ADDR/DATA/RESP sets flush_seen so the fill completes and acks but leaves valid=0; flush_seen cleared on IDLE entry.
REQ-022 fetch_req low on RESP cycle: ack still pulses, line still installed.
REQ-023 RREADY=0 and fetch_ack=0 outside DATA and RESP respectively (except hit ack in IDLE).
REQ-024 Miss latency: ARVALID cycle after request; ack one cycle after RLAST beat.

Reset
REQ-025 Reset → IDLE; valid=0, tag=0, words=0, cnt=0, err=0, flush_seen=0, req_addr=0.
REQ-026 Outputs after reset: ARVALID=0, RREADY=0, fetch_ack=0, fetch_err=0, fetch_data=0, ARADDR=0, ARLEN=3, ARSIZE=3'b010, ARBURST=2'b01, ARID=0.
REQ-027 Reset mid-burst abandons fill; remaining R beats are not accepted (RREADY=0).

Structure
REQ-028 AXI widths, RESP codes, BURST_INCR, SIZE_WORD, LINE_LEN=3 live in shared package axi_pkg; state enum local.
REQ-029 Sub-module fetch_line_buf holds words/tag/valid with write-beat and install ports; FSM in top.

Verification
REQ-030 Miss: fetch 0x0000_0008; ARREADY after 2 cycles; beats 0x11,0x22,0x33,0x44 RLAST on 4th -> ARADDR 0x0,ARLEN 3, ack data 0x33, err 0.
REQ-031 Hit: then fetch 0x0000_000C -> ack same cycle, data 0x44, ARVALID stays 0.
REQ-032 Error: fill with 3rd beat RRESP=2'b10 -> ack with err=1; next fetch 0x0 misses, ARVALID re-asserted.
REQ-033 Short burst: RLAST on 2nd beat -> ack err=1, valid=0.
REQ-034 Flush: flush pulse during DATA of line 0x100 -> ack data correct; fetch 0x104 re-misses.
REQ-035 Reset mid-DATA after 2 beats -> IDLE, RREADY=0 next cycle, fetch 0x0 misses.
